// File: rtl/mmm_pe_sequencer_if.sv
// Control bundle between the tile issuer and the PE-array sequencer.
// Master issues start/abort/k_len; slave drives PE and operand-buffer controls.
interface mmm_pe_sequencer_if #(
  parameter int K_WIDTH   = 8,
  parameter int ROW_WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic [K_WIDTH-1:0]   k_len;
  logic                 busy;
  logic                 pe_clear;
  logic                 pe_en;
  logic                 feed_en;
  logic [K_WIDTH-1:0]   op_addr;
  logic                 out_valid;
  logic [ROW_WIDTH-1:0] out_row;
  logic                 done;

  modport master (
    output start, abort, k_len,
    input  busy, pe_clear, pe_en, feed_en, op_addr, out_valid, out_row, done
  );

  modport slave (
    input  start, abort, k_len,
    output busy, pe_clear, pe_en, feed_en, op_addr, out_valid, out_row, done
  );
endinterface

// File: rtl/mmm_pe_sequencer.sv
// Tile sequencer for the systolic PE array: clear, feed k operands, flush the
// skew, drain one row per cycle, pulse done. Moore outputs only.
module mmm_pe_sequencer #(
  parameter int ARRAY_DIM = 4,
  parameter int K_WIDTH   = 8,
  parameter int ROW_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mmm_pe_sequencer_if.slave  bus
);
  localparam int CW = (K_WIDTH > ROW_WIDTH + 1) ? K_WIDTH : ROW_WIDTH + 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * ARRAY_DIM - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [K_WIDTH-1:0] k_lat, k_nx;
  logic [CW-1:0]      feed_last;

  // k_lat is nonzero whenever FEED is reachable, so the subtract cannot wrap.
  assign feed_last = CW'(k_lat) - CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      k_lat <= k_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    k_nx     = k_lat;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.start) begin
          if (bus.k_len != '0) begin
            state_nx = CLEAR;
            k_nx     = bus.k_len;
          end else begin
            state_nx = DONE;
          end
        end
      end
      CLEAR: begin
        state_nx = FEED;
        cnt_nx   = '0;
      end
      FEED: begin
        if (cnt == feed_last) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // DONE already returns to IDLE, so abort there changes nothing.
    if (bus.abort && state != IDLE) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.pe_clear  = (state == CLEAR);
    bus.pe_en     = (state == FEED) || (state == FLUSH);
    bus.feed_en   = (state == FEED);
    bus.op_addr   = (state == FEED) ? cnt[K_WIDTH-1:0] : '0;
    bus.out_valid = (state == DRAIN);
    bus.out_row   = (state == DRAIN) ? cnt[ROW_WIDTH-1:0] : '0;
    bus.done      = (state == DONE);
  end
endmodule

// File: tb/tb_mmm_pe_sequencer.sv
// Scoreboard bench: each launched tile pushes its expected per-cycle output
// vector; the negedge monitor pops and compares, expecting all-zero otherwise.
module tb_mmm_pe_sequencer;
  localparam int N  = 4;
  localparam int KW = 4;
  localparam int RW = 4;
  localparam int VW = 4 + KW + 1 + RW + 1;

  typedef struct {
    int            cyc;
    logic [VW-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  mmm_pe_sequencer_if #(.K_WIDTH(KW), .ROW_WIDTH(RW)) bus ();

  mmm_pe_sequencer #(.ARRAY_DIM(N), .K_WIDTH(KW), .ROW_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(input logic busy, input logic clr, input logic pe,
                                       input logic feed, input int addr, input logic ov,
                                       input int row, input logic dn);
    logic [KW-1:0] a;
    logic [RW-1:0] r;
    a = KW'(addr);
    r = RW'(row);
    return {busy, clr, pe, feed, a, ov, r, dn};
  endfunction

  // Tile whose start is seen in IDLE during cycle c0.
  task automatic push_tile(input int c0, input int k);
    int c;
    c = c0 + 1;
    if (k != 0) begin
      sb.push_back('{c, mk(1, 1, 0, 0, 0, 0, 0, 0)}); c++;
      for (int i = 0; i < k; i++) begin
        sb.push_back('{c, mk(1, 0, 1, 1, i, 0, 0, 0)}); c++;
      end
      for (int i = 0; i < 2 * N - 2; i++) begin
        sb.push_back('{c, mk(1, 0, 1, 0, 0, 0, 0, 0)}); c++;
      end
      for (int i = 0; i < N; i++) begin
        sb.push_back('{c, mk(1, 0, 0, 0, 0, 1, i, 0)}); c++;
      end
    end
    sb.push_back('{c, mk(1, 0, 0, 0, 0, 0, 0, 1)});
  endtask

  // Drop expectations for cycles after c (abort/reset seen at the next edge).
  task automatic truncate(input int c);
    while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int k);
    bus.k_len = KW'(k);
    bus.start = 1'b1;
    push_tile(cyc, k);
    tick(1);
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [VW-1:0] got;
    exp_t e;
    if (mon_en) begin
      got = {bus.busy, bus.pe_clear, bus.pe_en, bus.feed_en, bus.op_addr,
             bus.out_valid, bus.out_row, bus.done};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("tile_out", 32'(got), 32'(e.v));
      end else begin
        chk("idle_out", 32'(got), 32'(0));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.k_len = '0;
    tick(1);
    mon_en = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // basic tile, k=3
    launch(3);
    tick(16);

    // zero-length tile
    launch(0);
    tick(3);

    // second start mid-tile with new k_len is ignored
    launch(5);
    tick(5);
    bus.k_len = KW'(1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(14);

    // abort in FLUSH, then a clean relaunch
    launch(3);
    tick(6);
    bus.abort = 1'b1;
    truncate(cyc);
    tick(1);
    bus.abort = 1'b0;
    launch(3);
    tick(17);

    // reset mid-drain with start held through reset
    launch(3);
    tick(11);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    truncate(cyc);
    tick(2);
    reset = 1'b0;
    push_tile(cyc, 3);
    tick(1);
    bus.start = 1'b0;
    tick(17);

    // max length, start held through DONE relaunches on first IDLE cycle
    launch(15);
    tick(19);
    bus.start = 1'b1;
    tick(8);
    push_tile(cyc, 15);
    tick(1);
    bus.start = 1'b0;
    tick(30);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
